// File: rtl/xy_z_packer.sv
// -----------------------------------------------------------------------------
// xy_z_packer
//   Capture stage behind the z = x | ~y evaluator. Each accepted (x,y,z) beat
//   contributes one z bit, packed LSB-first into PACK_W-bit words, and one
//   error-mask bit that is set when z disagrees with x | ~y. Completed or
//   flushed words are presented on a valid/ready output. A saturating counter
//   tracks the total number of mismatching beats.
//
// Ports
//   clk, resetn            clock, synchronous active-low reset
//   in_valid / in_ready    beat handshake for x, y, z
//   flush                  single-cycle request to emit the partial word
//   out_valid / out_ready  word handshake
//   out_data               packed z bits, bit0 = first accepted beat
//   out_err_mask           per-bit mismatch flags
//   out_len                number of valid bits in the word (1..PACK_W)
//   err_count              saturating count of mismatching accepted beats
// -----------------------------------------------------------------------------
module xy_z_packer #(
    parameter int PACK_W = 8,
    parameter int CNT_W  = 16,
    localparam int LEN_W = $clog2(PACK_W + 1)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              x,
    input  logic              y,
    input  logic              z,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PACK_W-1:0] out_data,
    output logic [PACK_W-1:0] out_err_mask,
    output logic [LEN_W-1:0]  out_len,
    output logic [CNT_W-1:0]  err_count
);

    localparam int IDX_W = $clog2(PACK_W);

    // Accumulator stage
    logic [PACK_W-1:0] acc_data_q, acc_data_d;
    logic [PACK_W-1:0] acc_mask_q, acc_mask_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              flush_pend_q, flush_pend_d;

    // Output register stage
    logic              out_valid_q, out_valid_d;
    logic [PACK_W-1:0] out_data_q, out_data_d;
    logic [PACK_W-1:0] out_mask_q, out_mask_d;
    logic [LEN_W-1:0]  out_len_q, out_len_d;

    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

    logic              out_free;
    logic              last_slot;
    logic              beat_acc;
    logic              beat_err;
    logic              pend_load;
    logic [PACK_W-1:0] data_m, mask_m;
    logic [LEN_W-1:0]  count_m;

    always_comb begin
        out_free  = !out_valid_q || out_ready;
        last_slot = (idx_q == IDX_W'(PACK_W - 1));
        // Stall only when the next beat (or a pending flush) needs the output
        // register and it cannot be freed this cycle.
        in_ready  = resetn && !((last_slot || flush_pend_q) && !out_free);
        beat_acc  = in_valid && in_ready;
        beat_err  = z ^ (x | ~y);
        pend_load = flush_pend_q && out_free;

        // Accumulator contents with this cycle's beat merged in.
        data_m = acc_data_q;
        mask_m = acc_mask_q;
        if (beat_acc) begin
            data_m[idx_q] = z;
            mask_m[idx_q] = beat_err;
        end
        count_m = LEN_W'(idx_q) + LEN_W'(beat_acc);
    end

    always_comb begin
        acc_data_d   = acc_data_q;
        acc_mask_d   = acc_mask_q;
        idx_d        = idx_q;
        flush_pend_d = flush_pend_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_mask_d   = out_mask_q;
        out_len_d    = out_len_q;
        err_cnt_d    = err_cnt_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (pend_load) begin
            // The pending partial word is exactly what was held at flush time
            // (no beats are accepted while it waits). A beat arriving in the
            // load cycle starts a fresh word at bit0.
            out_valid_d  = 1'b1;
            out_data_d   = acc_data_q;
            out_mask_d   = acc_mask_q;
            out_len_d    = LEN_W'(idx_q);
            acc_data_d   = beat_acc ? PACK_W'(z) : '0;
            acc_mask_d   = beat_acc ? PACK_W'(beat_err) : '0;
            idx_d        = beat_acc ? IDX_W'(1) : '0;
            // A flush in the load cycle applies to the fresh word, which can
            // only go out once the register frees up again.
            flush_pend_d = flush && beat_acc;
        end else if (beat_acc && last_slot) begin
            // Full word; a simultaneous flush has nothing left to emit.
            out_valid_d = 1'b1;
            out_data_d  = data_m;
            out_mask_d  = mask_m;
            out_len_d   = LEN_W'(PACK_W);
            acc_data_d  = '0;
            acc_mask_d  = '0;
            idx_d       = '0;
        end else begin
            acc_data_d = data_m;
            acc_mask_d = mask_m;
            idx_d      = idx_q + IDX_W'(beat_acc);
            // flush_pend_q here means the register is still busy; a new flush
            // adds nothing because no beats arrived since the first one.
            if (flush && !flush_pend_q && count_m != '0) begin
                if (out_free) begin
                    out_valid_d = 1'b1;
                    out_data_d  = data_m;
                    out_mask_d  = mask_m;
                    out_len_d   = count_m;
                    acc_data_d  = '0;
                    acc_mask_d  = '0;
                    idx_d       = '0;
                end else begin
                    flush_pend_d = 1'b1;
                end
            end
        end

        if (beat_acc && beat_err && err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            acc_data_q   <= '0;
            acc_mask_q   <= '0;
            idx_q        <= '0;
            flush_pend_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_mask_q   <= '0;
            out_len_q    <= '0;
            err_cnt_q    <= '0;
        end else begin
            acc_data_q   <= acc_data_d;
            acc_mask_q   <= acc_mask_d;
            idx_q        <= idx_d;
            flush_pend_q <= flush_pend_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_mask_q   <= out_mask_d;
            out_len_q    <= out_len_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_err_mask = out_mask_q;
    assign out_len      = out_len_q;
    assign err_count    = err_cnt_q;

endmodule
